// File: rtl/counter_sweep_ctrl.sv
// Sweep controller: drives an external up/down counter between lo and hi
// as a triangle wave for a programmable number of periods.
module counter_sweep_ctrl #(
    parameter int W  = 4,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [RW-1:0] reps,
    input  logic [W-1:0]  cnt,
    output logic          ce,
    output logic          load,
    output logic [W-1:0]  load_val,
    output logic          up_down,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [W-1:0]  ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0] ONE_RW = {{(RW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [W-1:0]  lo_q_r;
    logic [W-1:0]  hi_q_r;
    logic [RW-1:0] reps_q_r;
    logic [RW-1:0] per_r;
    logic [RW-1:0] per_nxt_s;
    logic [W-1:0]  lo_q_nxt_s;
    logic          accept_s;
    logic          reject_s;

    logic          ce_r;
    logic          load_r;
    logic [W-1:0]  load_val_r;
    logic          up_down_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;

    // Next-state and period-counter logic; abort overrides everything while busy.
    always_comb begin
        state_nxt_s = state_r;
        per_nxt_s   = per_r;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && (hi <= lo)) begin
                    reject_s = 1'b1;
                end else if (start && !abort) begin
                    accept_s    = 1'b1;
                    per_nxt_s   = {RW{1'b0}};
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_UP;
                end
            end
            S_UP: begin
                // Turn one step early so the counter peaks exactly at hi_q.
                if (abort) begin
                    state_nxt_s = S_IDLE;
                end else if (cnt == (hi_q_r - ONE_W)) begin
                    state_nxt_s = S_DOWN;
                end else begin
                    state_nxt_s = S_UP;
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_nxt_s = S_IDLE;
                end else if (cnt == (lo_q_r + ONE_W)) begin
                    per_nxt_s = per_r + ONE_RW;
                    if ((reps_q_r != {RW{1'b0}}) && (per_r == (reps_q_r - ONE_RW))) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_UP;
                    end
                end else begin
                    state_nxt_s = S_DOWN;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // The load value must reflect lo in the same cycle it is captured.
    always_comb begin
        if (accept_s) begin
            lo_q_nxt_s = lo;
        end else begin
            lo_q_nxt_s = lo_q_r;
        end
    end

    // State, latched sweep parameters and period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            lo_q_r   <= {W{1'b0}};
            hi_q_r   <= {W{1'b0}};
            reps_q_r <= {RW{1'b0}};
            per_r    <= {RW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            per_r   <= per_nxt_s;
            lo_q_r  <= lo_q_nxt_s;
            if (accept_s) begin
                hi_q_r   <= hi;
                reps_q_r <= reps;
            end else begin
                hi_q_r   <= hi_q_r;
                reps_q_r <= reps_q_r;
            end
        end
    end

    // Outputs registered from the next state so they align with state_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_r       <= 1'b0;
            load_r     <= 1'b0;
            load_val_r <= {W{1'b0}};
            up_down_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            ce_r       <= (state_nxt_s == S_UP) || (state_nxt_s == S_DOWN);
            load_r     <= (state_nxt_s == S_LOAD);
            load_val_r <= (state_nxt_s == S_LOAD) ? lo_q_nxt_s : {W{1'b0}};
            up_down_r  <= (state_nxt_s == S_UP);
            busy_r     <= (state_nxt_s == S_LOAD) || (state_nxt_s == S_UP) ||
                          (state_nxt_s == S_DOWN);
            done_r     <= (state_nxt_s == S_DONE);
            err_r      <= reject_s;
        end
    end

    assign ce       = ce_r;
    assign load     = load_r;
    assign load_val = load_val_r;
    assign up_down  = up_down_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench for counter_sweep_ctrl with a behavioural model of the
// controlled counter closing the loop on cnt.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start, abort;
    logic [3:0] lo, hi;
    logic [7:0] reps;
    logic [3:0] cnt = 4'd0;
    logic       ce, load, up_down, busy, done, err;
    logic [3:0] load_val;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       ld;
        logic       ce;
        logic       up;
        logic       dn;
        logic       er;
        logic       bz;
        logic       chk;
        logic [3:0] c;
        logic [3:0] lv;
    } rec_t;

    rec_t exp_q[$];

    counter_sweep_ctrl #(.W(4), .RW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .lo(lo), .hi(hi), .reps(reps), .cnt(cnt),
        .ce(ce), .load(load), .load_val(load_val), .up_down(up_down),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Controlled counter model
    always @(posedge clk) begin
        if (load) cnt <= load_val;
        else if (ce) cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
        else cnt <= cnt;
    end

    // Monitor: every cycle with visible activity consumes one expected record
    always @(negedge clk) begin
        if (rst_n && (load || ce || done || err || busy)) begin
            rec_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got load=%0b ce=%0b up=%0b done=%0b err=%0b busy=%0b cnt=%0d, required no activity",
                         load, ce, up_down, done, err, busy, cnt);
            end else begin
                e = exp_q.pop_front();
                if (load !== e.ld || ce !== e.ce || up_down !== e.up || done !== e.dn ||
                    err !== e.er || busy !== e.bz || load_val !== e.lv || (e.chk && cnt !== e.c)) begin
                    errors++;
                    $display("FAIL seq_record @%0t: got ld=%0b ce=%0b up=%0b dn=%0b er=%0b bz=%0b cnt=%0d lv=%0d, required ld=%0b ce=%0b up=%0b dn=%0b er=%0b bz=%0b cnt=%0d lv=%0d",
                             $time, load, ce, up_down, done, err, busy, cnt, load_val,
                             e.ld, e.ce, e.up, e.dn, e.er, e.bz, e.c, e.lv);
                end
            end
        end
    end

    task automatic push(input logic ld, ce_e, up, dn, er, bz, ck,
                        input logic [3:0] c, lv);
        rec_t r;
        r.ld = ld; r.ce = ce_e; r.up = up; r.dn = dn; r.er = er;
        r.bz = bz; r.chk = ck; r.c = c; r.lv = lv;
        exp_q.push_back(r);
    endtask

    task automatic push_ld(input logic [3:0] lv);  push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, lv); endtask
    task automatic push_up(input logic [3:0] c);   push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c, 4'd0); endtask
    task automatic push_dn(input logic [3:0] c);   push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c, 4'd0); endtask
    task automatic push_done(input logic [3:0] c); push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, c, 4'd0); endtask
    task automatic push_err(input logic [3:0] c);  push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, c, 4'd0); endtask

    task automatic push_period(input logic [3:0] l, h);
        for (int v = int'(l); v < int'(h); v++) push_up(4'(v));
        for (int v = int'(h); v > int'(l); v--) push_dn(4'(v));
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d records outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ce"}, {31'd0, ce}, 32'd0);
        chk({nm, "_load"}, {31'd0, load}, 32'd0);
        chk({nm, "_load_val"}, {28'd0, load_val}, 32'd0);
        chk({nm, "_up_down"}, {31'd0, up_down}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
        chk({nm, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; lo = 4'd0; hi = 4'd0; reps = 8'd0;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single period; mid-sweep start and bound changes must be ignored
        lo = 4'd2; hi = 4'd5; reps = 8'd1;
        push_ld(4'd2); push_period(4'd2, 4'd5); push_done(4'd2);
        pulse_start();
        repeat (2) @(negedge clk);
        lo = 4'd0; hi = 4'd9; reps = 8'd0;
        pulse_start();
        wait_drain("single", 40);
        @(negedge clk);
        chk("single_cnt_rest", {28'd0, cnt}, 32'd2);
        chk("single_busy_idle", {31'd0, busy}, 32'd0);

        // Three periods, one done
        lo = 4'd2; hi = 4'd5; reps = 8'd3;
        push_ld(4'd2);
        for (int p = 0; p < 3; p++) push_period(4'd2, 4'd5);
        push_done(4'd2);
        pulse_start();
        wait_drain("multi", 60);
        @(negedge clk);
        chk("multi_cnt_rest", {28'd0, cnt}, 32'd2);

        // Rejected starts: equal bounds and inverted bounds
        lo = 4'd7; hi = 4'd7; reps = 8'd1;
        push_err(4'd2);
        pulse_start();
        wait_drain("reject_eq", 10);
        lo = 4'd9; hi = 4'd3;
        push_err(4'd2);
        pulse_start();
        wait_drain("reject_inv", 10);
        repeat (3) @(negedge clk);
        chk("reject_cnt", {28'd0, cnt}, 32'd2);
        chk("reject_busy", {31'd0, busy}, 32'd0);

        // Continuous run, abort in DOWN with cnt=2 during the third period
        lo = 4'd0; hi = 4'd3; reps = 8'd0;
        push_ld(4'd0);
        push_period(4'd0, 4'd3); push_period(4'd0, 4'd3);
        push_up(4'd0); push_up(4'd1); push_up(4'd2); push_dn(4'd3); push_dn(4'd2);
        pulse_start();
        repeat (17) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ce", {31'd0, ce}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_cnt", {28'd0, cnt}, 32'd1);
        chk("abort_queue", exp_q.size(), 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_cnt_frozen", {28'd0, cnt}, 32'd1);

        // Minimum span at the top of the range
        lo = 4'd14; hi = 4'd15; reps = 8'd2;
        push_ld(4'd14);
        push_up(4'd14); push_dn(4'd15); push_up(4'd14); push_dn(4'd15);
        push_done(4'd14);
        pulse_start();
        wait_drain("top", 30);
        @(negedge clk);
        chk("top_cnt_rest", {28'd0, cnt}, 32'd14);

        // Reset asserted between edges while in UP
        lo = 4'd2; hi = 4'd5; reps = 8'd1;
        push_ld(4'd2); push_up(4'd2);
        pulse_start();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        chk("midreset_queue", exp_q.size(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_load", {31'd0, load}, 32'd0);
        chk("post_reset_done", {31'd0, done}, 32'd0);
        chk("post_reset_cnt", {28'd0, cnt}, 32'd2);

        chk("final_queue", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
